pwm_multi_ch: RTL and testbench
===============================

# pwm_multi_ch

Parametrised multi-channel PWM generator for the motor drive path. Each channel produces a PWM waveform from programmable high/low cycle counts. New settings go into per-channel shadow registers and are applied only at period boundaries, so the waveform never glitches. Disabling a channel lets the current period finish before the output parks low. The block sits between the motion-control logic (speed/steering decisions) and the motor driver pins.

## Interface
Parameters:
- NUM_CH, 4: number of independent PWM channels (1..16)
- CNT_W, 8: width of high/low time fields, in clock cycles
- IDLE_LVL, 0: per-channel output level when IDLE, bit mask of NUM_CH bits

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  shadow write strobe, one cycle
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of write; out-of-range index ignored
- cfg_high  in  CNT_W  high-phase length, cycles
- cfg_low  in  CNT_W  low-phase length, cycles
- en  in  NUM_CH  per-channel run request, level
- pwm  out  NUM_CH  PWM outputs, registered
- period_fini  out  NUM_CH  one-cycle pulse on last cycle of each period, registered
- busy  out  NUM_CH  channel in RUN or DRAIN

## Operation
- Per channel: shadow_high/low (CNT_W), act_high/low (CNT_W), period counter cnt (CNT_W+1), state.
- States: IDLE, RUN, DRAIN.
  - IDLE: en=1 -> load act_* from shadow, cnt<=0, go RUN.
  - RUN: at boundary, reload act_* from shadow, cnt<=0. en=0 -> go DRAIN (no output change).
  - DRAIN: en=1 -> back to RUN, no gap. Boundary with en=0 -> IDLE.
- Period length P = act_high + act_low, computed in CNT_W+1 bits with no overflow.
- Output rules:
  - pwm = 1 while cnt < act_high, else 0.
  - Boundary is the cycle where cnt == P-1.
  - P==0: 1-cycle period, pwm 0, boundary every cycle.
- Corner settings:
  - act_high=0: pwm constantly low.
  - act_low=0, act_high>0: pwm constantly high; period_fini still pulses every act_high cycles.
- Shadow update:
  - cfg_we writes shadow of cfg_ch at the clock edge.
  - A write on the same edge as a boundary is NOT used for that reload. Active takes the old shadow; the new value applies at the following boundary.
  - Multiple writes within one period: last write wins.
- Channels are fully independent; no phase alignment between channels.

## Timing
- Reset (async, immediate):
  - state=IDLE, cnt=0, shadow=0, act=0
  - pwm=IDLE_LVL, period_fini=0, busy=0
- Start latency: en sampled high at edge k. pwm shows the first period cycle (cnt=0) during cycle k+1. busy=1 from k+1.
- period_fini: high exactly during the cycle where the registered cnt == P-1 (last cycle of the period). Aligned with the last pwm cycle of that period.
- Stop: en sampled low at edge k mid-period.
  - Waveform continues to the end of the current period.
  - Cycle after the boundary: pwm=IDLE_LVL bit, busy=0.
  - If en falls during the boundary cycle itself, next cycle is IDLE.
- DRAIN->RUN: en re-asserted before the boundary. Next period starts seamlessly with a shadow reload.
- Reset asserted mid-period: outputs go to reset values asynchronously. After release, a channel restarts only on a sampled en=1.
- Config to output: a shadow write lands at the first boundary strictly after the write edge.

## Structure
- Shared package pwm_pkg:
  - state enum (PWM_IDLE, PWM_RUN, PWM_DRAIN)
  - function computing channel index width (min 1 bit)
- Sub-module pwm_chan: one channel (shadow, active, counter, FSM, output registers), parameter CNT_W.
- Top instantiates NUM_CH copies via generate and decodes cfg_we/cfg_ch into per-channel write enables.

## Test plan
- Reset then idle: rst pulse with en=0 -> pwm=IDLE_LVL, period_fini=0, busy=0 for 50 cycles.
- Basic duty: ch0 cfg 20/10, en[0]=1 -> after 1-cycle latency, 20 high / 10 low repeating; period_fini every 30 cycles on the last low cycle.
- Glitch-free update:
  - ch1 running 5/5; write 8/2 mid-period -> current period stays 5/5, next is 8/2.
  - Write on the boundary edge -> takes effect one period later.
- Corners:
  - 0/7 -> pwm always 0.
  - 7/0 -> pwm always 1, period_fini every 7 cycles.
  - 0/0 -> pwm 0, period_fini every cycle.
  - 255/255 with CNT_W=8 -> 510-cycle period, no wrap.
- Graceful stop:
  - ch2 running 4/4; deassert en at cnt=2 -> completes to cnt=7, then pwm=IDLE_LVL.
  - Reassert en at cnt=5 -> continuous waveform, busy never drops.
- Async reset mid-period plus channel independence: all 4 channels running different settings, rst asserted between edges -> all outputs to reset values immediately; other channels unaffected by writes to ch3 and by an out-of-range cfg_ch.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

    // Per-channel sequencing state.
    typedef enum logic [1:0] {
        PWM_IDLE  = 2'd0,
        PWM_RUN   = 2'd1,
        PWM_DRAIN = 2'd2
    } pwm_state_e;

    // Width of a channel index; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow and active high/low times, period counter,
// IDLE/RUN/DRAIN sequencing and registered pwm/period_fini/busy outputs.
// Active settings only change at period boundaries, so the waveform never
// glitches.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int   CNT_W    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [CNT_W-1:0] low_i,
    input  logic             en_i,
    output logic             pwm_o,
    output logic             fini_o,
    output logic             busy_o
);

    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

    pwm_state_e       state_q, state_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] shd_high_q, shd_low_q;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic [CNT_W-1:0] act_low_q, act_low_d;
    logic             pwm_q, pwm_d;
    logic             fini_q, fini_d;
    logic             busy_q, busy_d;
    logic [CNT_W:0]   per_q, per_d;
    logic             boundary;

    // Last cycle of a period; a zero-length period is one cycle long.
    function automatic logic is_last(input logic [CNT_W:0] cnt, input logic [CNT_W:0] per);
        return (per == '0) || (cnt == per - ONE);
    endfunction

    // Period lengths carry one extra bit so 2^CNT_W-1 + 2^CNT_W-1 never wraps.
    assign per_q    = {1'b0, act_high_q} + {1'b0, act_low_q};
    assign per_d    = {1'b0, act_high_d} + {1'b0, act_low_d};
    assign boundary = (state_q != PWM_IDLE) && is_last(cnt_q, per_q);

    // Next-state: start, period reload, drain and park decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + ONE;
        act_high_d = act_high_q;
        act_low_d  = act_low_q;
        case (state_q)
            PWM_IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d    = PWM_RUN;
                    act_high_d = shd_high_q;
                    act_low_d  = shd_low_q;
                end
            end
            PWM_RUN, PWM_DRAIN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (en_i) begin
                        state_d    = PWM_RUN;
                        act_high_d = shd_high_q;
                        act_low_d  = shd_low_q;
                    end else begin
                        state_d = PWM_IDLE;
                    end
                end else begin
                    state_d = en_i ? PWM_RUN : PWM_DRAIN;
                end
            end
            default: begin
                state_d = PWM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next counter/settings so they register
    // in step with the counter they describe.
    always_comb begin
        busy_d = (state_d != PWM_IDLE);
        pwm_d  = busy_d ? (cnt_d < {1'b0, act_high_d}) : IDLE_BIT;
        fini_d = busy_d && is_last(cnt_d, per_d);
    end

    // Sequencing, active settings and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PWM_IDLE;
            cnt_q      <= '0;
            act_high_q <= '0;
            act_low_q  <= '0;
            pwm_q      <= IDLE_BIT;
            fini_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_high_q <= act_high_d;
            act_low_q  <= act_low_d;
            pwm_q      <= pwm_d;
            fini_q     <= fini_d;
            busy_q     <= busy_d;
        end
    end

    // Shadow settings; the reload reads the pre-edge value, so a write on a
    // boundary edge waits for the following boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shd_high_q <= '0;
            shd_low_q  <= '0;
        end else if (we_i) begin
            shd_high_q <= high_i;
            shd_low_q  <= low_i;
        end
    end

    assign pwm_o  = pwm_q;
    assign fini_o = fini_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: decodes the shared config port into
// per-channel shadow write strobes and replicates independent channels.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int                NUM_CH   = 4,
    parameter int                CNT_W    = 8,
    parameter logic [NUM_CH-1:0] IDLE_LVL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]              cfg_high,
    input  logic [CNT_W-1:0]              cfg_low,
    input  logic [NUM_CH-1:0]             en,
    output logic [NUM_CH-1:0]             pwm,
    output logic [NUM_CH-1:0]             period_fini,
    output logic [NUM_CH-1:0]             busy
);

    localparam int IDX_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] ch_we;

    // Write-enable decode; indices at or above NUM_CH match no channel.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_we[i] = cfg_we && (cfg_ch == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_chan #(
            .CNT_W    (CNT_W),
            .IDLE_BIT (IDLE_LVL[g])
        ) u_chan (
            .clk_i  (clk),
            .rst_i  (rst),
            .we_i   (ch_we[g]),
            .high_i (cfg_high),
            .low_i  (cfg_low),
            .en_i   (en[g]),
            .pwm_o  (pwm[g]),
            .fini_o (period_fini[g]),
            .busy_o (busy[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch. Expected output vectors are built
// from the programmed high/low times and queued; each negedge pops one and
// compares it with the registered outputs.
module tb_pwm_multi_ch;

    localparam int                NUM_CH   = 6;
    localparam int                CNT_W    = 8;
    localparam logic [NUM_CH-1:0] IDLE_LVL = 6'b100100;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_low;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] period_fini;
    logic [NUM_CH-1:0] busy;

    typedef struct packed {
        logic [NUM_CH-1:0] p;
        logic [NUM_CH-1:0] f;
        logic [NUM_CH-1:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    pwm_multi_ch #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .IDLE_LVL (IDLE_LVL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
        .en          (en),
        .pwm         (pwm),
        .period_fini (period_fini),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t idle_vec();
        exp_t e;
        e.p = IDLE_LVL;
        e.f = '0;
        e.b = '0;
        return e;
    endfunction

    // One period of channel ch with the given times; other channels idle.
    function automatic void push_period(int ch, int h, int l);
        exp_t e;
        int   per;
        per = h + l;
        if (per == 0) begin
            e = idle_vec();
            e.p[ch] = 1'b0;
            e.f[ch] = 1'b1;
            e.b[ch] = 1'b1;
            sb.push_back(e);
        end else begin
            for (int i = 0; i < per; i++) begin
                e = idle_vec();
                e.p[ch] = (i < h);
                e.f[ch] = (i == per - 1);
                e.b[ch] = 1'b1;
                sb.push_back(e);
            end
        end
    endfunction

    function automatic void push_idle(int n);
        for (int i = 0; i < n; i++) sb.push_back(idle_vec());
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        en     = '0;
        cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_cfg(int ch, int h, int l);
        cfg_we   = 1'b1;
        cfg_ch   = 3'(ch);
        cfg_high = CNT_W'(h);
        cfg_low  = CNT_W'(l);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        en  = '0;
        repeat (2) @(negedge clk);
        e = idle_vec();
        n_cmp++;
        if ({pwm, period_fini, busy} !== e) begin
            n_bad++;
            $display("FAIL reset_hold got pwm=%b fini=%b busy=%b want %b/%b/%b",
                     pwm, period_fini, busy, e.p, e.f, e.b);
        end
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL reset_idle k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
        end
    endtask

    task automatic test_basic_duty();
        exp_t e;
        do_reset();
        write_cfg(0, 20, 10);
        en[0] = 1'b1;
        repeat (3) push_period(0, 20, 10);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL basic_duty k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
        end
    endtask

    task automatic test_glitch_free();
        exp_t e;
        do_reset();
        write_cfg(1, 5, 5);
        en[1] = 1'b1;
        push_period(1, 5, 5);
        push_period(1, 8, 2);
        push_period(1, 8, 2);
        push_period(1, 3, 3);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL glitch_free k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
            if (k == 2) begin
                cfg_we = 1'b1; cfg_ch = 3'd1; cfg_high = 8'd8; cfg_low = 8'd2;
            end
            if (k == 19) begin
                cfg_we = 1'b1; cfg_ch = 3'd1; cfg_high = 8'd3; cfg_low = 8'd3;
            end
        end
    endtask

    task automatic test_corner(int h, int l, int nper);
        exp_t e;
        do_reset();
        write_cfg(0, h, l);
        en[0] = 1'b1;
        repeat (nper) push_period(0, h, l);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL corner_%0d_%0d k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         h, l, k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
        end
    endtask

    task automatic test_graceful_stop();
        exp_t e;
        do_reset();
        write_cfg(2, 4, 4);
        en[2] = 1'b1;
        push_period(2, 4, 4);
        push_period(2, 4, 4);
        push_idle(5);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL stop_drain k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
            if (k == 10) en[2] = 1'b0;
        end
        en[2] = 1'b1;
        repeat (3) push_period(2, 4, 4);
        push_idle(3);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL stop_resume k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
            if (k == 10) en[2] = 1'b0;
            if (k == 13) en[2] = 1'b1;
            if (k == 23) en[2] = 1'b0;
        end
    endtask

    task automatic test_reset_independence();
        localparam int N = 40;
        int   hv[4];
        int   lv[4];
        exp_t ev[N];
        exp_t e;
        int   t, np, h, l, per;
        hv = '{3, 4, 2, 6};
        lv = '{2, 4, 5, 1};
        do_reset();
        for (int c = 0; c < 4; c++) write_cfg(c, hv[c], lv[c]);
        en[3:0] = 4'hF;
        for (int i = 0; i < N; i++) ev[i] = idle_vec();
        for (int c = 0; c < 4; c++) begin
            t  = 0;
            np = 0;
            while (t < N) begin
                h   = (c == 3 && np > 0) ? 1 : hv[c];
                l   = (c == 3 && np > 0) ? 1 : lv[c];
                per = h + l;
                for (int i = 0; i < per && t < N; i++) begin
                    ev[t].p[c] = (i < h);
                    ev[t].f[c] = (i == per - 1);
                    ev[t].b[c] = 1'b1;
                    t++;
                end
                np++;
            end
        end
        for (int i = 0; i < N; i++) sb.push_back(ev[i]);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL independence k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
            if (k == 4) begin
                cfg_we = 1'b1; cfg_ch = 3'd3; cfg_high = 8'd1; cfg_low = 8'd1;
            end
            if (k == 6) begin
                cfg_we = 1'b1; cfg_ch = 3'd7; cfg_high = 8'd9; cfg_low = 8'd9;
            end
            if (k == 8) begin
                cfg_we = 1'b1; cfg_ch = 3'd6; cfg_high = 8'd9; cfg_low = 8'd9;
            end
        end
        #2;
        rst = 1'b1;
        en  = '0;
        #1;
        e = idle_vec();
        n_cmp++;
        if ({pwm, period_fini, busy} !== e) begin
            n_bad++;
            $display("FAIL async_reset got pwm=%b fini=%b busy=%b want %b/%b/%b",
                     pwm, period_fini, busy, e.p, e.f, e.b);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_idle(5);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL post_reset_idle k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
        end
        en[0] = 1'b1;
        repeat (3) push_period(0, 0, 0);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm, period_fini, busy} !== e) begin
                n_bad++;
                $display("FAIL post_reset_restart k=%0d got pwm=%b fini=%b busy=%b want %b/%b/%b",
                         k, pwm, period_fini, busy, e.p, e.f, e.b);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_high = '0;
        cfg_low  = '0;
        en       = '0;
        n_cmp    = 0;
        n_bad    = 0;
        test_reset();
        test_basic_duty();
        test_glitch_free();
        test_corner(0, 7, 3);
        test_corner(7, 0, 3);
        test_corner(0, 0, 5);
        test_corner(255, 255, 2);
        test_graceful_stop();
        test_reset_independence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
